// File: rtl/memory_pkg.sv
// Shared types for the dual-port memory slice.
//   read_mode_t   : same-address read/write collision behaviour.
//   clear_state_t : power-up clear sequencer states.
package memory_pkg;

  typedef enum logic {
    READ_FIRST,
    WRITE_FIRST
  } read_mode_t;

  typedef enum logic {
    CLEAR,
    READY
  } clear_state_t;

endpackage

// File: rtl/memory_clear_sequencer.sv
// Walks every array address once after reset, requesting an all-zero write at each,
// then raises ready and stays idle until the next reset.
// Ports:
//   clk, reset     : clock and synchronous active-high reset.
//   clear_active   : high while the sequencer owns the write port.
//   clear_address  : address to zero this cycle (valid when clear_active).
//   ready          : registered, high once every address has been cleared.
module memory_clear_sequencer
  import memory_pkg::*;
#(
  parameter int unsigned DATADEPTH    = 1024,
  parameter int unsigned ADDRESSWIDTH = $clog2(DATADEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    clear_active,
  output logic [ADDRESSWIDTH-1:0] clear_address,
  output logic                    ready
);

  localparam logic [ADDRESSWIDTH-1:0] LastAddr = ADDRESSWIDTH'(DATADEPTH - 1);

  clear_state_t            state_q;
  logic [ADDRESSWIDTH-1:0] count_q;
  logic                    ready_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      count_q <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          // The edge that zeroes the last word also hands the port to the user.
          if (count_q == LastAddr) begin
            state_q <= READY;
            count_q <= '0;
            ready_q <= 1'b1;
          end else begin
            count_q <= count_q + ADDRESSWIDTH'(1);
          end
        end
        READY: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= CLEAR;
          count_q <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign clear_active  = (state_q == CLEAR);
  assign clear_address = count_q;
  assign ready         = ready_q;

endmodule

// File: rtl/dual_port_memory.sv
// Simple-dual-port synchronous RAM with per-byte write masks, selectable
// read-during-write behaviour, optional output register and a zeroing sequence
// after reset.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset.
//   ready                          : high once the post-reset clear has finished.
//   write_en, write_mask,
//   write_address, data_in         : write port; mask bit i enables lane i.
//   read_en, read_address          : read port.
//   data_out, read_valid           : read response, valid for one cycle per read.
module dual_port_memory
  import memory_pkg::*;
#(
  parameter int unsigned DATAWIDTH    = 32,
  parameter int unsigned BYTEWIDTH    = 8,
  parameter int unsigned DATADEPTH    = 1024,
  parameter int unsigned ADDRESSWIDTH = $clog2(DATADEPTH),
  parameter read_mode_t  READMODE     = READ_FIRST,
  parameter int unsigned OUTPUT_REG   = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  output logic                             ready,
  input  logic                             write_en,
  input  logic [DATAWIDTH/BYTEWIDTH-1:0]   write_mask,
  input  logic [ADDRESSWIDTH-1:0]          write_address,
  input  logic [DATAWIDTH-1:0]             data_in,
  input  logic                             read_en,
  input  logic [ADDRESSWIDTH-1:0]          read_address,
  output logic [DATAWIDTH-1:0]             data_out,
  output logic                             read_valid
);

  localparam int unsigned Lanes = DATAWIDTH / BYTEWIDTH;

  if (DATAWIDTH % BYTEWIDTH != 0) begin : gen_width_check
    $error("DATAWIDTH must be a multiple of BYTEWIDTH");
  end

  logic                    clear_active;
  logic [ADDRESSWIDTH-1:0] clear_address;

  memory_clear_sequencer #(
    .DATADEPTH    (DATADEPTH),
    .ADDRESSWIDTH (ADDRESSWIDTH)
  ) u_clear_sequencer (
    .clk           (clk),
    .reset         (reset),
    .clear_active  (clear_active),
    .clear_address (clear_address),
    .ready         (ready)
  );

  logic [DATAWIDTH-1:0] mem_q [DATADEPTH];

  logic                 user_we;
  logic                 read_accept;
  logic                 rd_in_range;
  logic [DATAWIDTH-1:0] old_word;
  logic [DATAWIDTH-1:0] merged_word;
  logic [DATAWIDTH-1:0] rd_word;
  logic                 bypass;

  // Out-of-range writes are dropped rather than aliased onto a real word.
  assign user_we     = ready && write_en && (32'(write_address) < DATADEPTH);
  assign read_accept = ready && read_en;
  assign rd_in_range = 32'(read_address) < DATADEPTH;

  // Clear sequencer has priority; the user port is only live once ready is high.
  always_ff @(posedge clk) begin
    if (clear_active) begin
      mem_q[clear_address] <= '0;
    end else if (user_we) begin
      for (int i = 0; i < Lanes; i++) begin
        if (write_mask[i]) begin
          mem_q[write_address][i*BYTEWIDTH +: BYTEWIDTH] <= data_in[i*BYTEWIDTH +: BYTEWIDTH];
        end
      end
    end
  end

  always_comb begin
    old_word = '0;
    if (rd_in_range) begin
      old_word = mem_q[read_address];
    end
    merged_word = old_word;
    for (int i = 0; i < Lanes; i++) begin
      if (write_mask[i]) begin
        merged_word[i*BYTEWIDTH +: BYTEWIDTH] = data_in[i*BYTEWIDTH +: BYTEWIDTH];
      end
    end
    // user_we already implies an in-range write address, so a match implies in-range read.
    bypass  = (READMODE == WRITE_FIRST) && user_we && (write_address == read_address);
    rd_word = bypass ? merged_word : old_word;
  end

  logic [DATAWIDTH-1:0] rd_data_q;
  logic                 rd_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= read_accept;
      if (read_accept) begin
        rd_data_q <= rd_word;
      end
    end
  end

  if (OUTPUT_REG != 0) begin : gen_out_reg
    logic [DATAWIDTH-1:0] out_data_q;
    logic                 out_valid_q;

    // Second stage only loads on a valid response so data_out holds between reads.
    always_ff @(posedge clk) begin
      if (reset) begin
        out_data_q  <= '0;
        out_valid_q <= 1'b0;
      end else begin
        out_valid_q <= rd_valid_q;
        if (rd_valid_q) begin
          out_data_q <= rd_data_q;
        end
      end
    end

    assign data_out   = out_data_q;
    assign read_valid = out_valid_q;
  end else begin : gen_no_out_reg
    assign data_out   = rd_data_q;
    assign read_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_dual_port_memory.sv
// Three instances share one stimulus stream:
//   0: depth 16, READ_FIRST,  no output register
//   1: depth 16, WRITE_FIRST, no output register
//   2: depth 12, READ_FIRST,  output register
// A reference model (word arrays, readiness counters, latency queues) predicts
// every output after every edge; a vector table and hand sequences add fixed
// expectations for the named corner cases.
module tb_dual_port_memory;
  import memory_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        write_en = 1'b0;
  logic [3:0]  write_mask = '0;
  logic [3:0]  write_address = '0;
  logic [31:0] data_in = '0;
  logic        read_en = 1'b0;
  logic [3:0]  read_address = '0;

  logic        rdy [3];
  logic        rv  [3];
  logic [31:0] dout [3];

  always #5 clk = ~clk;

  dual_port_memory #(
    .DATAWIDTH(32), .BYTEWIDTH(8), .DATADEPTH(16), .ADDRESSWIDTH(4),
    .READMODE(READ_FIRST), .OUTPUT_REG(0)
  ) u_rf (
    .clk(clk), .reset(reset), .ready(rdy[0]), .write_en(write_en),
    .write_mask(write_mask), .write_address(write_address), .data_in(data_in),
    .read_en(read_en), .read_address(read_address), .data_out(dout[0]),
    .read_valid(rv[0])
  );

  dual_port_memory #(
    .DATAWIDTH(32), .BYTEWIDTH(8), .DATADEPTH(16), .ADDRESSWIDTH(4),
    .READMODE(WRITE_FIRST), .OUTPUT_REG(0)
  ) u_wf (
    .clk(clk), .reset(reset), .ready(rdy[1]), .write_en(write_en),
    .write_mask(write_mask), .write_address(write_address), .data_in(data_in),
    .read_en(read_en), .read_address(read_address), .data_out(dout[1]),
    .read_valid(rv[1])
  );

  dual_port_memory #(
    .DATAWIDTH(32), .BYTEWIDTH(8), .DATADEPTH(12), .ADDRESSWIDTH(4),
    .READMODE(READ_FIRST), .OUTPUT_REG(1)
  ) u_pr (
    .clk(clk), .reset(reset), .ready(rdy[2]), .write_en(write_en),
    .write_mask(write_mask), .write_address(write_address), .data_in(data_in),
    .read_en(read_en), .read_address(read_address), .data_out(dout[2]),
    .read_valid(rv[2])
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic        v;
    logic [31:0] d;
  } resp_t;

  int unsigned dep [3] = '{16, 16, 12};
  bit          wfm [3] = '{1'b0, 1'b1, 1'b0};
  int unsigned lat [3] = '{1, 1, 2};

  logic [31:0] mem [3][16];
  int unsigned clr [3] = '{0, 0, 0};
  resp_t       pq [3][$];
  logic        exp_v [3];
  logic [31:0] exp_d [3];
  logic        exp_rdy [3];

  int nchk = 0;
  int nerr = 0;

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = m[i] ? nw[i*8 +: 8] : old[i*8 +: 8];
    return r;
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        clr[k] = 0;
        for (int a = 0; a < 16; a++) mem[k][a] = '0;
        pq[k].delete();
        for (int j = 1; j < int'(lat[k]); j++) pq[k].push_back('{1'b0, 32'h0});
        exp_v[k] = 1'b0;
        exp_d[k] = '0;
        exp_rdy[k] = 1'b0;
      end else begin
        bit          live;
        bit          acc;
        logic [31:0] rdata;
        resp_t       r;
        live  = clr[k] >= dep[k];
        acc   = live && read_en;
        rdata = '0;
        if (acc && int'(read_address) < int'(dep[k])) begin
          rdata = mem[k][read_address];
          if (wfm[k] && write_en && write_address == read_address)
            rdata = merge(rdata, data_in, write_mask);
        end
        if (live && write_en && int'(write_address) < int'(dep[k]))
          mem[k][write_address] = merge(mem[k][write_address], data_in, write_mask);
        if (clr[k] < dep[k]) clr[k]++;
        pq[k].push_back('{acc, rdata});
        r = pq[k].pop_front();
        exp_v[k] = r.v;
        if (r.v) exp_d[k] = r.d;
        exp_rdy[k] = clr[k] >= dep[k];
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    nchk++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ready[%0d]", k), 32'(rdy[k]), 32'(exp_rdy[k]));
      chk($sformatf("read_valid[%0d]", k), 32'(rv[k]), 32'(exp_v[k]));
      chk($sformatf("data_out[%0d]", k), dout[k], exp_d[k]);
    end
  endtask

  task automatic idle();
    write_en = 1'b0;
    read_en  = 1'b0;
  endtask

  // Counts edges from reset release to ready; optionally hammers the ports meanwhile.
  task automatic measure_clear(input bit poke, output int t0, output int t2);
    t0 = 0;
    t2 = 0;
    for (int e = 1; e <= 40 && (t0 == 0 || t2 == 0); e++) begin
      write_en      = poke && !exp_rdy[2];
      write_mask    = 4'hF;
      write_address = 4'd2;
      data_in       = 32'hFFFF_FFFF;
      read_en       = poke && !exp_rdy[2];
      read_address  = 4'd2;
      step();
      if (rdy[0] && t0 == 0) t0 = e;
      if (rdy[2] && t2 == 0) t2 = e;
    end
    idle();
  endtask

  task automatic sweep();
    for (int a = 0; a < 16; a++) begin
      read_en      = 1'b1;
      read_address = 4'(a);
      step();
    end
    idle();
    step();
    step();
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  mask;
    logic [3:0]  waddr;
    logic [31:0] din;
    logic        re;
    logic [3:0]  raddr;
    logic        ev;
    logic [31:0] e_rf;
    logic [31:0] e_wf;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int t0, t2;

    vecs[0] = '{1'b1, 4'hF, 4'd5, 32'hAABB_CCDD, 1'b0, 4'd0, 1'b0, 32'h0, 32'h0};
    vecs[1] = '{1'b1, 4'h5, 4'd5, 32'h1122_3344, 1'b0, 4'd0, 1'b0, 32'h0, 32'h0};
    vecs[2] = '{1'b0, 4'h0, 4'd0, 32'h0,         1'b1, 4'd5, 1'b1, 32'hAA22_CC44, 32'hAA22_CC44};
    vecs[3] = '{1'b1, 4'hF, 4'd3, 32'hDEAD_BEEF, 1'b1, 4'd3, 1'b1, 32'h0, 32'hDEAD_BEEF};
    vecs[4] = '{1'b0, 4'h0, 4'd0, 32'h0,         1'b1, 4'd3, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[5] = '{1'b1, 4'h0, 4'd7, 32'h5555_5555, 1'b1, 4'd7, 1'b1, 32'h0, 32'h0};

    // Reset for three cycles, then time the clear while poking both ports.
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    measure_clear(1'b1, t0, t2);
    chk("clear_len_depth16", 32'(t0), 32'd16);
    chk("clear_len_depth12", 32'(t2), 32'd12);
    sweep();

    // Reset again once the counter has reached 7; the clear must restart from 0.
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (7) step();
    chk("mid_clear_not_ready", 32'(rdy[0]), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    measure_clear(1'b0, t0, t2);
    chk("restart_len_depth16", 32'(t0), 32'd16);
    chk("restart_len_depth12", 32'(t2), 32'd12);

    // Byte-mask and collision vectors.
    foreach (vecs[i]) begin
      write_en      = vecs[i].we;
      write_mask    = vecs[i].mask;
      write_address = vecs[i].waddr;
      data_in       = vecs[i].din;
      read_en       = vecs[i].re;
      read_address  = vecs[i].raddr;
      step();
      chk($sformatf("vec%0d_valid", i), 32'(rv[0]), 32'(vecs[i].ev));
      if (vecs[i].ev) begin
        chk($sformatf("vec%0d_read_first", i), dout[0], vecs[i].e_rf);
        chk($sformatf("vec%0d_write_first", i), dout[1], vecs[i].e_wf);
      end
    end
    idle();
    step();

    // Pipeline: preload 0..3 with 1..4, then four back-to-back reads.
    for (int a = 0; a < 4; a++) begin
      write_en      = 1'b1;
      write_mask    = 4'hF;
      write_address = 4'(a);
      data_in       = 32'(a + 1);
      step();
    end
    idle();
    step();
    for (int s = 0; s < 7; s++) begin
      read_en      = (s < 4);
      read_address = 4'(s);
      step();
      chk($sformatf("pipe_valid_s%0d", s), 32'(rv[2]), 32'(s >= 1 && s <= 4));
      if (s >= 1) chk($sformatf("pipe_data_s%0d", s), dout[2], 32'(s > 4 ? 4 : s));
      chk($sformatf("nopipe_valid_s%0d", s), 32'(rv[0]), 32'(s <= 3));
      if (s <= 3) chk($sformatf("nopipe_data_s%0d", s), dout[0], 32'(s + 1));
    end
    idle();

    // Out of range on the depth-12 instance (in range on the others).
    write_en      = 1'b1;
    write_mask    = 4'hF;
    write_address = 4'd13;
    data_in       = 32'hCAFE_F00D;
    step();
    idle();
    sweep();
    read_en      = 1'b1;
    read_address = 4'd13;
    step();
    idle();
    step();
    chk("oor_read_valid", 32'(rv[2]), 32'd1);
    chk("oor_read_zero", dout[2], 32'h0);

    // Randomized traffic against the model, with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      reset         = ($urandom_range(0, 299) == 0);
      write_en      = $urandom_range(0, 1) == 1;
      write_mask    = 4'($urandom);
      write_address = 4'($urandom_range(0, 15));
      data_in       = $urandom;
      read_en       = $urandom_range(0, 2) != 0;
      read_address  = ($urandom_range(0, 2) == 0) ? write_address : 4'($urandom_range(0, 15));
      step();
    end
    reset = 1'b0;
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
